// File: rtl/jk_register_bank_if.sv
// jk_register_bank_if: control inputs and state outputs of the register bank
interface jk_register_bank_if #(parameter int WIDTH = 8);
  logic             i_preset;
  logic             i_en;
  logic [1:0]       i_mode;
  logic [WIDTH-1:0] i_j;
  logic [WIDTH-1:0] i_k;
  logic             i_err_clr;
  logic [WIDTH-1:0] o_q;
  logic [WIDTH-1:0] o_qn;
  logic [WIDTH-1:0] o_changed;
  logic             o_sr_err;
  modport master (output i_preset, i_en, i_mode, i_j, i_k, i_err_clr, input o_q, o_qn, o_changed, o_sr_err);
  modport slave (input i_preset, i_en, i_mode, i_j, i_k, i_err_clr, output o_q, o_qn, o_changed, o_sr_err);
endinterface

// File: rtl/jk_register_bank.sv
// jk_register_bank: WIDTH-bit bank of JK/D/T/SR flip-flops with preset, change flags and sticky SR error
module jk_register_bank #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter logic [WIDTH-1:0] PRESET_VALUE = '1
) (
  input logic                clock,
  input logic                reset,
  jk_register_bank_if.slave  bus
);
  logic [WIDTH-1:0] r_q, r_changed;
  logic             r_sr_err;
  logic [WIDTH-1:0] w_jk, w_sr, w_mode_nxt, w_nxt;
  logic             w_sr_set;
  // an illegal S=R=1 bit falls into the hold term, so it keeps its value
  assign w_jk       = (bus.i_j & ~r_q) | (~bus.i_k & r_q);
  assign w_sr       = (bus.i_j & ~bus.i_k) | (r_q & ~(bus.i_j ^ bus.i_k));
  assign w_mode_nxt = bus.i_mode == 2'b00 ? w_jk :
                      bus.i_mode == 2'b01 ? bus.i_j :
                      bus.i_mode == 2'b10 ? r_q ^ bus.i_j : w_sr;
  assign w_nxt      = bus.i_preset ? PRESET_VALUE : bus.i_en ? w_mode_nxt : r_q;
  assign w_sr_set   = bus.i_en && bus.i_mode == 2'b11 && !bus.i_preset && |(bus.i_j & bus.i_k);
  always_ff @(posedge clock) begin
    if (reset) begin
      r_q       <= RESET_VALUE;
      r_changed <= '0;
      r_sr_err  <= 1'b0;
    end else begin
      r_q       <= w_nxt;
      r_changed <= r_q ^ w_nxt;
      r_sr_err  <= w_sr_set | (r_sr_err & ~bus.i_err_clr);
    end
  end
  assign bus.o_q       = r_q;
  assign bus.o_qn      = ~r_q;
  assign bus.o_changed = r_changed;
  assign bus.o_sr_err  = r_sr_err;
endmodule

// File: tb/tb_jk_register_bank.sv
// tb_jk_register_bank: directed checks of the 4-bit register bank in all modes
module tb_jk_register_bank;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  jk_register_bank_if #(.WIDTH(4)) bus ();
  jk_register_bank #(.WIDTH(4)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  task automatic drive(input logic rs, input logic pr, input logic en, input logic [1:0] md,
                       input logic [3:0] j, input logic [3:0] k, input logic clr);
    reset         = rs;
    bus.i_preset  = pr;
    bus.i_en      = en;
    bus.i_mode    = md;
    bus.i_j       = j;
    bus.i_k       = k;
    bus.i_err_clr = clr;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [3:0] q, input logic [3:0] ch, input logic err);
    chk({tag, "_q"}, bus.o_q, q);
    chk({tag, "_qn"}, bus.o_qn, ~q);
    chk({tag, "_changed"}, bus.o_changed, ch);
    chk({tag, "_sr_err"}, {3'b000, bus.o_sr_err}, {3'b000, err});
  endtask
  initial begin
    drive(1, 0, 1, 2'($urandom_range(3)), 4'($urandom), 4'($urandom), 0);
    chk_all("reset1", 4'b0000, 4'b0000, 0);
    drive(1, 0, 1, 2'b11, 4'b1111, 4'b1111, 0);
    chk_all("reset2", 4'b0000, 4'b0000, 0);
    drive(0, 0, 1, 2'b00, 4'b1100, 4'b1010, 0);
    chk_all("jk1", 4'b1100, 4'b1100, 0);
    drive(0, 0, 1, 2'b00, 4'b1100, 4'b1010, 0);
    chk_all("jk2", 4'b0100, 4'b1000, 0);
    drive(0, 0, 1, 2'b01, 4'b1010, 4'b1111, 0);
    chk_all("d", 4'b1010, 4'b1110, 0);
    drive(0, 0, 1, 2'b10, 4'b0011, 4'b0000, 0);
    chk_all("t", 4'b1001, 4'b0011, 0);
    drive(0, 0, 0, 2'b10, 4'b1111, 4'b0000, 0);
    chk_all("hold", 4'b1001, 4'b0000, 0);
    drive(0, 0, 1, 2'b01, 4'b0000, 4'b0000, 0);
    chk_all("d0", 4'b0000, 4'b1001, 0);
    drive(0, 0, 1, 2'b11, 4'b0110, 4'b0011, 0);
    chk_all("sr_ill", 4'b0100, 4'b0100, 1);
    drive(0, 0, 1, 2'b00, 4'b0000, 4'b0000, 0);
    chk_all("err_sticky", 4'b0100, 4'b0000, 1);
    drive(0, 0, 1, 2'b11, 4'b0110, 4'b0011, 1);
    chk_all("set_wins", 4'b0100, 4'b0000, 1);
    drive(0, 0, 0, 2'b11, 4'b0110, 4'b0011, 1);
    chk_all("err_clr", 4'b0100, 4'b0000, 0);
    drive(0, 0, 1, 2'b11, 4'b1000, 4'b0100, 0);
    chk_all("sr_legal", 4'b1000, 4'b1100, 0);
    drive(0, 0, 1, 2'b01, 4'b0101, 4'b0000, 0);
    chk_all("d5", 4'b0101, 4'b1101, 0);
    drive(0, 1, 0, 2'b00, 4'b0000, 4'b1111, 0);
    chk_all("preset", 4'b1111, 4'b1010, 0);
    drive(0, 1, 1, 2'b11, 4'b1111, 4'b1111, 0);
    chk_all("preset_no_err", 4'b1111, 4'b0000, 0);
    drive(1, 1, 1, 2'b01, 4'b1111, 4'b0000, 0);
    chk_all("preset_reset", 4'b0000, 4'b0000, 0);
    drive(0, 0, 1, 2'b11, 4'b0001, 4'b0001, 0);
    chk_all("err_again", 4'b0000, 4'b0000, 1);
    drive(0, 0, 1, 2'b10, 4'b1111, 4'b0000, 0);
    chk_all("tog1", 4'b1111, 4'b1111, 1);
    drive(0, 0, 1, 2'b10, 4'b1111, 4'b0000, 0);
    chk_all("tog2", 4'b0000, 4'b1111, 1);
    drive(0, 0, 1, 2'b10, 4'b1111, 4'b0000, 0);
    chk_all("tog3", 4'b1111, 4'b1111, 1);
    drive(1, 0, 1, 2'b10, 4'b1111, 4'b0000, 0);
    chk_all("mid_reset", 4'b0000, 4'b0000, 0);
    drive(0, 0, 1, 2'b10, 4'b1111, 4'b0000, 0);
    chk_all("resume", 4'b1111, 4'b1111, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
